pid_controller_v2: RTL and testbench
====================================

# pid_controller_v2

Parametrised, pipelined PID controller with sample-valid handshake, runtime integrator clamp (anti-windup), output saturation and status flags. It sits between the ADC sample path and the DAC/actuator path of a feedback loop and replaces the fixed-width free-running PID. It processes one sample per `in_valid` at up to one sample per clock.

## Interface
- `DATA_WIDTH`, 14: signed width of `data_in` and `set_point`.
- `COEF_WIDTH`, 14: signed width of `p_coef`, `i_coef` and `d_coef`.
- `FRAC_BITS`, 12: fractional bits of the coefficients; the sum is shifted right by this amount.
- `OUT_WIDTH`, 14: signed width of `data_out`.
- `ACC_WIDTH`, DATA_WIDTH+COEF_WIDTH+8: signed width of the integrator accumulator.

Ports:
- `clk`, in, 1: single clock; all logic is on the rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `in_valid`, in, 1: `data_in` is a new sample.
- `data_in`, in, DATA_WIDTH: measured value, signed.
- `set_point`, in, DATA_WIDTH: target value, signed; sampled with `in_valid`.
- `p_coef`, `i_coef`, `d_coef`, in, COEF_WIDTH each: signed gains in Q(FRAC_BITS); sampled with `in_valid`.
- `int_limit`, in, ACC_WIDTH-1: unsigned integrator clamp magnitude.
- `int_clr`, in, 1: synchronous clear of the integrator and derivative history.
- `int_hold`, in, 1: freeze the integrator.
- `out_valid`, out, 1: `data_out` is updated this cycle.
- `data_out`, out, OUT_WIDTH: saturated controller output, signed.
- `out_sat`, out, 1: `data_out` was clipped for this sample.
- `int_sat`, out, 1: the integrator sits at ±`int_limit`.

## Operation
- Stage 1 (on `in_valid`): `e = set_point - data_in`, DATA_WIDTH+1 bits, exact. Coefficients are registered alongside `e`.
- Stage 2:
  - `p = p_coef*e`.
  - `de = e - e_prev` (DATA_WIDTH+2 bits), then `d = d_coef*de`.
  - `acc_next = clamp(acc + i_coef*e, -int_limit, +int_limit)`, computed in ACC_WIDTH+1 bits before the clamp so no wrap is possible.
  - `e_prev <= e`.
- Stage 3:
  - `sum = p + acc_next + d` in ACC_WIDTH+2 bits.
  - Arithmetic shift right by FRAC_BITS (floor toward −∞).
  - Saturate to [−2^(OUT_WIDTH−1), 2^(OUT_WIDTH−1)−1]; `out_sat` = clip occurred.
- The integrator and `e_prev` update only on valid samples. Bubbles propagate unchanged; there is no backpressure.
- `int_hold` = 1: `acc` keeps its value. The P and D terms still update, and `acc_next` = `acc` is used in the sum.
- `int_clr` = 1: `acc` <= 0 and `e_prev` <= 0. This has priority over `int_hold` and over integration.
  - If `int_clr` and a stage-2 valid arrive together: `acc` <= 0, the sum uses `acc_next` = 0, and `e_prev` <= `e` of this sample.
- `int_limit` = 0 forces the integrator to 0 with `int_sat` = 1.
- `int_limit` is not latched; a change takes effect on the next integration and clamps an out-of-range `acc` immediately on that sample.
- `int_sat` = 1 whenever |`acc`| == `int_limit` after an update. It holds until the next update or clear.

## Timing
- Latency: `in_valid` at cycle N gives `out_valid` at N+3. Throughput is 1 sample/clock.
- `data_out`, `out_sat` and `int_sat` hold between valid outputs.
- Reset values:
  - `out_valid`, `out_sat`, `int_sat` = 0.
  - `data_out` = 0.
  - `acc`, `e_prev` and all pipeline valids = 0.
- Reset mid-operation: in-flight samples are discarded, and no `out_valid` occurs until 3 cycles after the first post-reset `in_valid`.
- `int_clr` acts in the cycle it is high and has no pipeline delay.

## Configuration
- `PID_DERIVATIVE_EN` defined: the D path (`e_prev`, `de`, the `d_coef` multiplier) is built.
- `PID_DERIVATIVE_EN` undefined:
  - `d` is the constant 0.
  - `d_coef` is an unused input.
  - `e_prev` is not instantiated.
  - Latency and all other behaviour are unchanged.

## Structure
- Package `pid_pkg`: width helper functions (error, product and sum widths), and the saturate and clamp functions shared by the top level and the sub-module.
- Sub-module `pid_integrator`: owns `acc`, the clamp, `int_hold`/`int_clr` priority and `int_sat`.
- The top level holds the error stage, the P/D multipliers, the sum/shift/saturate stage and the valid pipeline.

## Test plan
All scenarios use the default parameters and `PID_DERIVATIVE_EN` defined unless stated.
- P only: `set_point` 4096, `data_in` 2048, `p_coef` 4096, `i_coef` = `d_coef` = 0, one valid → `data_out` 2048 at +3 cycles, `out_sat` 0.
- I only: `i_coef` 1, `e` 2048 constant, `int_limit` max, 4 consecutive valids → outputs 0, 1, 1, 2. `int_hold` high for the next 2 samples keeps the output at 2. `int_clr` pulse gives 0 on the next output.
- Clamp: `i_coef` 4096, `e` 2048, `int_limit` 10000 → first output 2, `int_sat` 1. Negating `e` drives the output to −3 with `int_sat` 1.
- Saturation: `p_coef` 8191, `set_point` 4095, `data_in` −4096 → `data_out` 8191, `out_sat` 1. Negated gain gives −8192, `out_sat` 1.
- Derivative: `d_coef` 4096, `set_point` 0, `data_in` steps from 0 to 1000 → one output of −1000, then 0. With `PID_DERIVATIVE_EN` undefined the output stays 0.
- Reset/bubbles:
  - `in_valid` pattern 1,0,1 gives `out_valid` pattern 1,0,1, each delayed by 3 cycles.
  - `rst_n` low with 2 samples in flight → no `out_valid` emerges and all outputs read 0.
  - `int_clr` together with `in_valid` → the sum uses `acc` = 0.

Source files
------------

// File: rtl/pid_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pid_pkg
//  Description : Shared width helpers plus the symmetric clamp and the
//                two's-complement saturate used by the PID datapath. All
//                arithmetic helpers work on a 64-bit signed carrier; callers
//                slice the result back to their own width.
//  Revision    : 1.0 - initial release
// ============================================================================
package pid_pkg;

    typedef logic signed [63:0] wide_t;

    // set_point - data_in needs one extra bit to be exact
    function automatic int err_width(input int dw);
        return dw + 1;
    endfunction

    // e - e_prev spans two error ranges, hence two extra bits over the data
    function automatic int diff_width(input int dw);
        return dw + 2;
    endfunction

    function automatic int prod_width(input int aw, input int bw);
        return aw + bw;
    endfunction

    // p + acc + d: two guard bits over the accumulator are enough because
    // both product terms are narrower than the accumulator
    function automatic int sum_width(input int accw);
        return accw + 2;
    endfunction

    // Clamp x into [-lim, +lim]; lim is non-negative
    function automatic wide_t clamp_sym(input wide_t x, input wide_t lim);
        if (x > lim) begin
            return lim;
        end else if (x < -lim) begin
            return -lim;
        end
        return x;
    endfunction

    // Saturate x into the range of a w-bit signed number
    function automatic wide_t saturate(input wide_t x, input int w);
        wide_t hi;
        wide_t lo;
        hi = (wide_t'(1) <<< (w - 1)) - wide_t'(1);
        lo = -hi - wide_t'(1);
        if (x > hi) begin
            return hi;
        end else if (x < lo) begin
            return lo;
        end
        return x;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pid_integrator.sv
`default_nettype none
// ============================================================================
//  Module      : pid_integrator
//  Description : Integrator of the PID controller. Owns the accumulator,
//                the runtime clamp to +/-i_limit, clear/hold priority and
//                the "integrator at limit" flag.
//                Ports:
//                  clk, rst_n      clock, async active-low reset
//                  i_valid         a sample is in stage 2 this cycle
//                  i_err           error of that sample (signed)
//                  i_icoef         integral gain (signed, Q format)
//                  i_limit         unsigned clamp magnitude (not latched)
//                  i_clr, i_hold   clear (wins) / freeze the accumulator
//                  o_acc           accumulator (acc_next of the last sample)
//                  o_int_sat       |acc| == i_limit after the last update
//  Revision    : 1.0 - initial release
// ============================================================================
module pid_integrator
    import pid_pkg::*;
#(
    parameter int ERR_WIDTH  = 15,
    parameter int COEF_WIDTH = 14,
    parameter int ACC_WIDTH  = 36
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        i_valid,
    input  logic signed [ERR_WIDTH-1:0] i_err,
    input  logic signed [COEF_WIDTH-1:0] i_icoef,
    input  logic        [ACC_WIDTH-2:0] i_limit,
    input  logic                        i_clr,
    input  logic                        i_hold,
    output logic signed [ACC_WIDTH-1:0] o_acc,
    output logic                        o_int_sat
);

    localparam int c_PW = prod_width(ERR_WIDTH, COEF_WIDTH);
    localparam int c_SW = ACC_WIDTH + 1;

    logic signed [c_PW-1:0]      w_prod;
    logic signed [c_SW-1:0]      w_sum;
    wide_t                       w_lim;
    wide_t                       w_clamped;
    logic signed [ACC_WIDTH-1:0] w_acc_next;
    logic                        w_sat_next;
    logic                        w_sat_hold;
    logic                        w_unused_hi;

    assign w_prod = c_PW'(i_icoef) * c_PW'(i_err);
    // One bit wider than the accumulator so the add can never wrap before
    // the clamp sees it
    assign w_sum  = c_SW'(o_acc) + c_SW'(w_prod);
    assign w_lim  = wide_t'({1'b0, i_limit});

    always_comb begin
        w_clamped  = clamp_sym(wide_t'(w_sum), w_lim);
        w_acc_next = w_clamped[ACC_WIDTH-1:0];
        w_sat_next = (w_clamped == w_lim) || (w_clamped == -w_lim);
        w_sat_hold = (wide_t'(o_acc) == w_lim) || (wide_t'(o_acc) == -w_lim);
    end

    // The clamped value fits ACC_WIDTH because |i_limit| < 2^(ACC_WIDTH-1)
    assign w_unused_hi = ^w_clamped[63:ACC_WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_acc     <= '0;
            o_int_sat <= 1'b0;
        end else if (i_clr) begin
            // Clear wins over hold and over a sample in flight; with a zero
            // limit a cleared integrator already sits at its limit
            o_acc     <= '0;
            o_int_sat <= (i_limit == '0);
        end else if (i_valid) begin
            if (i_hold) begin
                o_int_sat <= w_sat_hold;
            end else begin
                o_acc     <= w_acc_next;
                o_int_sat <= w_sat_next;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/pid_controller_v2.sv
`default_nettype none
// ============================================================================
//  Module      : pid_controller_v2
//  Description : Three-stage pipelined PID controller with sample-valid
//                handshake, clamped integrator (anti-windup), output
//                saturation and status flags. One sample per clock.
//                  stage 1: e = set_point - data_in, gains registered
//                  stage 2: p, d products, integrator update
//                  stage 3: sum, >>> FRAC_BITS, saturate
//                Build option: define PID_DERIVATIVE_EN to build the D path;
//                otherwise d = 0 and d_coef is ignored.
//                Ports:
//                  clk, rst_n               clock, async active-low reset
//                  in_valid, data_in        new measured sample
//                  set_point, p/i/d_coef    sampled with in_valid
//                  int_limit                integrator clamp magnitude
//                  int_clr, int_hold        integrator clear / freeze
//                  out_valid, data_out      result, 3 cycles after in_valid
//                  out_sat, int_sat         output clipped / integ. at limit
//  Revision    : 1.0 - initial release
// ============================================================================
module pid_controller_v2
    import pid_pkg::*;
#(
    parameter int DATA_WIDTH = 14,
    parameter int COEF_WIDTH = 14,
    parameter int FRAC_BITS  = 12,
    parameter int OUT_WIDTH  = 14,
    parameter int ACC_WIDTH  = DATA_WIDTH + COEF_WIDTH + 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    input  logic signed [DATA_WIDTH-1:0]  data_in,
    input  logic signed [DATA_WIDTH-1:0]  set_point,
    input  logic signed [COEF_WIDTH-1:0]  p_coef,
    input  logic signed [COEF_WIDTH-1:0]  i_coef,
    input  logic signed [COEF_WIDTH-1:0]  d_coef,
    input  logic        [ACC_WIDTH-2:0]   int_limit,
    input  logic                          int_clr,
    input  logic                          int_hold,
    output logic                          out_valid,
    output logic signed [OUT_WIDTH-1:0]   data_out,
    output logic                          out_sat,
    output logic                          int_sat
);

    localparam int c_EW   = err_width(DATA_WIDTH);
    localparam int c_DW   = diff_width(DATA_WIDTH);
    localparam int c_PW   = prod_width(c_EW, COEF_WIDTH);
    localparam int c_DPW  = prod_width(c_DW, COEF_WIDTH);
    localparam int c_SUMW = sum_width(ACC_WIDTH);

    // ---------------- stage 1: error and gains ----------------
    logic                         r_v1;
    logic signed [c_EW-1:0]       r_e;
    logic signed [COEF_WIDTH-1:0] r_p_coef;
    logic signed [COEF_WIDTH-1:0] r_i_coef;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1     <= 1'b0;
            r_e      <= '0;
            r_p_coef <= '0;
            r_i_coef <= '0;
        end else begin
            r_v1 <= in_valid;
            if (in_valid) begin
                r_e      <= c_EW'(set_point) - c_EW'(data_in);
                r_p_coef <= p_coef;
                r_i_coef <= i_coef;
            end
        end
    end

    // ---------------- stage 2: P, D and integrator ----------------
    logic                        r_v2;
    logic signed [c_PW-1:0]      r_p;
    logic signed [c_DPW-1:0]     w_d_term;
    logic signed [ACC_WIDTH-1:0] w_acc;
    logic                        w_int_sat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v2 <= 1'b0;
            r_p  <= '0;
        end else begin
            r_v2 <= r_v1;
            if (r_v1) begin
                r_p <= c_PW'(r_p_coef) * c_PW'(r_e);
            end
        end
    end

`ifdef PID_DERIVATIVE_EN
    logic signed [COEF_WIDTH-1:0] r_d_coef;
    logic signed [c_EW-1:0]       r_e_prev;
    logic signed [c_DW-1:0]       w_de;
    logic signed [c_DPW-1:0]      r_d;

    assign w_de     = c_DW'(r_e) - c_DW'(r_e_prev);
    assign w_d_term = r_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_d_coef <= '0;
            r_e_prev <= '0;
            r_d      <= '0;
        end else begin
            if (in_valid) begin
                r_d_coef <= d_coef;
            end
            if (r_v1) begin
                r_d <= c_DPW'(r_d_coef) * c_DPW'(w_de);
            end
            // A clear coinciding with a sample still records that sample as
            // history; a clear on an empty slot zeroes the history
            if (r_v1) begin
                r_e_prev <= r_e;
            end else if (int_clr) begin
                r_e_prev <= '0;
            end
        end
    end
`else
    logic w_unused_dcoef;

    assign w_unused_dcoef = ^d_coef;
    assign w_d_term       = '0;
`endif

    pid_integrator #(
        .ERR_WIDTH  (c_EW),
        .COEF_WIDTH (COEF_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH)
    ) u_integrator (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_valid   (r_v1),
        .i_err     (r_e),
        .i_icoef   (r_i_coef),
        .i_limit   (int_limit),
        .i_clr     (int_clr),
        .i_hold    (int_hold),
        .o_acc     (w_acc),
        .o_int_sat (w_int_sat)
    );

    // ---------------- stage 3: sum, scale, saturate ----------------
    // The accumulator register already holds acc_next of the sample now in
    // stage 3, since it was written on the same edge as r_p / r_d
    logic signed [c_SUMW-1:0] w_sum;
    logic signed [c_SUMW-1:0] w_shift;
    wide_t                    w_sat;
    logic                     w_clip;
    logic                     w_unused_sat;

    assign w_sum   = c_SUMW'(r_p) + c_SUMW'(w_acc) + c_SUMW'(w_d_term);
    assign w_shift = w_sum >>> FRAC_BITS;

    always_comb begin
        w_sat  = saturate(wide_t'(w_shift), OUT_WIDTH);
        w_clip = (w_sat != wide_t'(w_shift));
    end

    assign w_unused_sat = ^w_sat[63:OUT_WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            data_out  <= '0;
            out_sat   <= 1'b0;
            int_sat   <= 1'b0;
        end else begin
            out_valid <= r_v2;
            if (r_v2) begin
                data_out <= w_sat[OUT_WIDTH-1:0];
                out_sat  <= w_clip;
                int_sat  <= w_int_sat;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pid_controller_v2.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pid_controller_v2
//  Description : Directed bench for pid_controller_v2 with hand-computed
//                expected outputs, latency and bubble spacing checks.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pid_controller_v2;

    localparam int c_DW = 14;
    localparam int c_CW = 14;
    localparam int c_OW = 14;
    localparam int c_AW = c_DW + c_CW + 8;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    in_valid = 1'b0;
    logic signed [c_DW-1:0]  data_in = '0;
    logic signed [c_DW-1:0]  set_point = '0;
    logic signed [c_CW-1:0]  p_coef = '0;
    logic signed [c_CW-1:0]  i_coef = '0;
    logic signed [c_CW-1:0]  d_coef = '0;
    logic        [c_AW-2:0]  int_limit = '1;
    logic                    int_clr = 1'b0;
    logic                    int_hold = 1'b0;
    logic                    out_valid;
    logic signed [c_OW-1:0]  data_out;
    logic                    out_sat;
    logic                    int_sat;

    pid_controller_v2 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .data_in   (data_in),
        .set_point (set_point),
        .p_coef    (p_coef),
        .i_coef    (i_coef),
        .d_coef    (d_coef),
        .int_limit (int_limit),
        .int_clr   (int_clr),
        .int_hold  (int_hold),
        .out_valid (out_valid),
        .data_out  (data_out),
        .out_sat   (out_sat),
        .int_sat   (int_sat)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic signed [63:0] data;
        logic               osat;
        logic               isat;
        int                 lat;
        int                 cyc;
    } obs_t;

    obs_t q[$];
    int   sent_q[$];
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Monitor on the falling edge: inputs (driven just after the rising
    // edge) and outputs are both stable here
    initial forever begin
        obs_t o;
        @(negedge clk);
        cyc++;
        if (rst_n && out_valid) begin
            o.data = data_out;
            o.osat = out_sat;
            o.isat = int_sat;
            o.cyc  = cyc;
            o.lat  = (sent_q.size() != 0) ? cyc - sent_q.pop_front() : -1;
            q.push_back(o);
        end
        if (rst_n && in_valid) sent_q.push_back(cyc);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic sample(input int sp, input int din);
        set_point = c_DW'(sp);
        data_in   = c_DW'(din);
        in_valid  = 1'b1;
        tick();
        in_valid  = 1'b0;
    endtask

    task automatic pulse_clr();
        int_clr = 1'b1;
        tick();
        int_clr = 1'b0;
    endtask

    task automatic expect_out(input string tag, input int d, input logic os,
                              input logic is, output int ocyc);
        obs_t o;
        int   guard;
        guard = 0;
        ocyc  = 0;
        while (q.size() == 0 && guard < 12) begin
            tick();
            guard++;
        end
        check({tag, "/present"}, (q.size() != 0), 1);
        if (q.size() == 0) return;
        o    = q.pop_front();
        ocyc = o.cyc;
        check({tag, "/data"}, o.data, d);
        check({tag, "/out_sat"}, o.osat, os);
        check({tag, "/int_sat"}, o.isat, is);
        check({tag, "/latency"}, o.lat, 3);
    endtask

    initial begin
        int c1;
        int c2;
        int exp_d;

        // ---------------- reset state ----------------
        idle(2);
        #1;
        check("rst/out_valid", out_valid, 0);
        check("rst/data_out", data_out, 0);
        check("rst/out_sat", out_sat, 0);
        check("rst/int_sat", int_sat, 0);
        rst_n = 1'b1;
        idle(2);

        // ---------------- P only ----------------
        p_coef = 14'sd4096;
        sample(4096, 2048);
        expect_out("p_only", 2048, 0, 0, c1);
        idle(2);

        // ---------------- I only, hold, clear ----------------
        p_coef = '0;
        i_coef = 14'sd1;
        pulse_clr();
        repeat (4) sample(2048, 0);
        expect_out("i_only0", 0, 0, 0, c1);
        expect_out("i_only1", 1, 0, 0, c1);
        expect_out("i_only2", 1, 0, 0, c1);
        expect_out("i_only3", 2, 0, 0, c1);
        int_hold = 1'b1;
        repeat (2) sample(2048, 0);
        idle(4);
        int_hold = 1'b0;
        expect_out("hold0", 2, 0, 0, c1);
        expect_out("hold1", 2, 0, 0, c1);
        pulse_clr();
        sample(2048, 0);
        expect_out("after_clr", 0, 0, 0, c1);
        idle(2);

        // ---------------- clamp ----------------
        i_coef    = 14'sd4096;
        int_limit = 35'd10000;
        pulse_clr();
        sample(2048, 0);
        sample(-2048, 0);
        expect_out("clamp_pos", 2, 0, 1, c1);
        expect_out("clamp_neg", -3, 0, 1, c1);
        int_limit = '0;
        sample(2048, 0);
        expect_out("limit_zero", 0, 0, 1, c1);
        idle(2);

        // ---------------- output saturation ----------------
        i_coef    = '0;
        int_limit = '1;
        pulse_clr();
        p_coef = 14'sd8191;
        sample(4095, -4096);
        p_coef = -14'sd8191;
        sample(4095, -4096);
        expect_out("sat_pos", 8191, 1, 0, c1);
        expect_out("sat_neg", -8192, 1, 0, c1);
        idle(2);

        // ---------------- derivative ----------------
        p_coef = '0;
        d_coef = 14'sd4096;
        pulse_clr();
        sample(0, 0);
        sample(0, 1000);
        sample(0, 1000);
`ifdef PID_DERIVATIVE_EN
        exp_d = -1000;
`else
        exp_d = 0;
`endif
        expect_out("deriv0", 0, 0, 0, c1);
        expect_out("deriv_step", exp_d, 0, 0, c1);
        expect_out("deriv_flat", 0, 0, 0, c1);
        d_coef = '0;
        idle(2);

        // ---------------- bubbles 1,0,1 ----------------
        p_coef = 14'sd4096;
        sample(100, 0);
        idle(1);
        sample(100, 0);
        expect_out("bubble_a", 100, 0, 0, c1);
        expect_out("bubble_b", 100, 0, 0, c2);
        check("bubble/spacing", c2 - c1, 2);
        idle(2);

        // ---------------- int_clr together with a sample ----------------
        p_coef    = '0;
        i_coef    = 14'sd4096;
        int_limit = 35'd10000;
        pulse_clr();
        sample(2048, 0);
        expect_out("pre_clr", 2, 0, 1, c1);
        set_point = 14'sd2048;
        data_in   = '0;
        in_valid  = 1'b1;
        tick();
        in_valid  = 1'b0;
        int_clr   = 1'b1;
        tick();
        int_clr   = 1'b0;
        expect_out("clr_with_valid", 0, 0, 0, c1);
        idle(2);

        // ---------------- reset with samples in flight ----------------
        i_coef    = '0;
        p_coef    = 14'sd4096;
        int_limit = '0;
        sample(100, 0);
        expect_out("pre_rst", 100, 0, 1, c1);
        sample(100, 0);
        sample(100, 0);
        rst_n = 1'b0;
        sent_q.delete();
        idle(2);
        check("midrst/out_valid", out_valid, 0);
        check("midrst/data_out", data_out, 0);
        check("midrst/out_sat", out_sat, 0);
        check("midrst/int_sat", int_sat, 0);
        rst_n = 1'b1;
        idle(6);
        check("midrst/no_output", q.size(), 0);
        q.delete();
        int_limit = '1;
        sample(100, 0);
        expect_out("post_rst", 100, 0, 0, c1);
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
`default_nettype wire
